// File: rtl/conv_window_gen.sv
// conv_window_gen
// ---------------
// Feeds the 3x3 convolution engine. Takes a raster-order pixel stream (all
// channels of one pixel per beat), keeps the two previous image rows in line
// buffers, and emits every fully-interior 3x3 multi-channel window together
// with the coordinates of its centre pixel. Border pixels never become
// window centres, so each frame yields (IMG_H-2) x (IMG_W-2) windows.
//
// Ports
//   clk         clock; all logic on the rising edge
//   rst         synchronous reset, active-high
//   in_valid    pixel beat valid
//   in_ready    block can accept a beat
//   in_data     pixel; channel n at bits [n*PIX_W +: PIX_W]
//   out_valid   window valid
//   out_ready   consumer accepts window
//   out_window  tap k = 3*dy+dx (dy=0 top row, dx=0 left column) at
//               bits [k*CH*PIX_W +: CH*PIX_W], channels packed as in_data
//   out_row     centre row of the window
//   out_col     centre column of the window
//   frame_done  one-cycle pulse after the last pixel of a frame is accepted
//
// Handshake: a transfer happens on a cycle where valid && ready are both high.
// A valid output holds its payload stable until it is taken; the producer side
// never drops valid without a transfer. The output stage is one register deep,
// so in_ready = !out_valid || out_ready: a new beat is taken only when the
// window it might produce has somewhere to go.

module conv_window_gen #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = 8,
  parameter int CH    = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CH*PIX_W-1:0]          in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [9*CH*PIX_W-1:0]        out_window,
  output logic [$clog2(IMG_H)-1:0]     out_row,
  output logic [$clog2(IMG_W)-1:0]     out_col,
  output logic                         frame_done
);

  localparam int PW = CH * PIX_W;
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  // Position of the next pixel to arrive.
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic accept;
  logic emit;
  logic last_col;
  logic last_row;

  // lb_top holds the row two above the incoming one, lb_mid the row directly
  // above. Each column slot is rotated top <- mid <- new on every accept.
  logic [PW-1:0] lb_top [IMG_W];
  logic [PW-1:0] lb_mid [IMG_W];
  logic [PW-1:0] top_rd;
  logic [PW-1:0] mid_rd;

  // Working 3x3 window, index k = 3*dy + dx, and its shifted successor.
  logic [PW-1:0] win       [9];
  logic [PW-1:0] win_shift [9];
  logic [9*PW-1:0] win_flat;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign last_col = (col == CW'(IMG_W - 1));
  assign last_row = (row == RW'(IMG_H - 1));

  // Only pixels at row>=2, col>=2 complete a window whose every tap belongs
  // to the current frame and current three columns; anything else would
  // expose stale line-buffer rows or stale window columns.
  assign emit = accept && (row >= RW'(2)) && (col >= CW'(2));

  // Pre-write contents: the column being overwritten this cycle is exactly
  // the one that feeds the new right-hand window column.
  assign top_rd = lb_top[col];
  assign mid_rd = lb_mid[col];

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      win_shift[k] = '0;
    end
    for (int dy = 0; dy < 3; dy++) begin
      win_shift[3*dy]     = win[3*dy + 1];
      win_shift[3*dy + 1] = win[3*dy + 2];
    end
    win_shift[2] = top_rd;
    win_shift[5] = mid_rd;
    win_shift[8] = in_data;

    win_flat = '0;
    for (int k = 0; k < 9; k++) begin
      win_flat[k*PW +: PW] = win_shift[k];
    end
  end

  // Pixel storage. Contents are don't-care after reset because the emit
  // gating never exposes anything written before the current frame's rows
  // 0..1 and columns 0..1 have refilled it.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top[col] <= mid_rd;
      lb_mid[col] <= in_data;
      for (int k = 0; k < 9; k++) begin
        win[k] <= win_shift[k];
      end
    end
  end

  // Position counters and the one-deep output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
      out_valid  <= 1'b0;
      out_window <= '0;
      out_row    <= '0;
      out_col    <= '0;
    end else begin
      frame_done <= 1'b0;

      if (accept) begin
        if (last_col) begin
          col <= '0;
          if (last_row) begin
            row        <= '0;
            frame_done <= 1'b1;
          end else begin
            row <= row + RW'(1);
          end
        end else begin
          col <= col + CW'(1);
        end
      end

      // A new window may land in the same cycle the old one is taken; the
      // load wins and out_valid stays high.
      if (emit) begin
        out_valid  <= 1'b1;
        out_window <= win_flat;
        out_row    <= row - RW'(1);
        out_col    <= col - CW'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen. A 4x4 instance carries the main scenarios; a
// 5x3 instance covers a non-square image with a single row of windows.
// The reference keeps the received image in a 2-D array and builds each
// expected window straight from it by coordinates.

module tb_conv_window_gen;

  localparam int W     = 4;
  localparam int H     = 4;
  localparam int PIX_W = 8;
  localparam int CH    = 3;
  localparam int PW    = CH * PIX_W;
  localparam int WW    = 9 * PW;
  localparam int EW    = WW + 4;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------------------------------------------------------- DUT 4x4
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [WW-1:0] out_window;
  logic [1:0]    out_row;
  logic [1:0]    out_col;
  logic          frame_done;

  conv_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PIX_W), .CH(CH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_window(out_window),
    .out_row(out_row), .out_col(out_col), .frame_done(frame_done)
  );

  // ---------------------------------------------------------------- DUT 5x3
  logic          in_valid2 = 1'b0;
  logic          in_ready2;
  logic [PW-1:0] in_data2 = '0;
  logic          out_valid2;
  logic          out_ready2 = 1'b1;
  logic [WW-1:0] out_window2;
  logic [1:0]    out_row2;
  logic [2:0]    out_col2;
  logic          frame_done2;

  conv_window_gen #(.IMG_W(5), .IMG_H(3), .PIX_W(PIX_W), .CH(CH)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_window(out_window2),
    .out_row(out_row2), .out_col(out_col2), .frame_done(frame_done2)
  );

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [PW-1:0] pix(input int base, input int r, input int c);
    logic [PW-1:0] p;
    for (int n = 0; n < CH; n++) p[n*PIX_W +: PIX_W] = 8'(base + 16*r + 4*c + n);
    return p;
  endfunction

  // ---------------------------------------------------------------- reference
  logic [PW-1:0] img [H][W];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] e;
  int            mr = 0, mc = 0;
  logic          exp_fd = 1'b0;
  logic          hold_prev = 1'b0;
  logic [WW-1:0] sv_win;
  logic [1:0]    sv_row, sv_col;

  // Logs used by the directed checks.
  int            cent_q[$];
  int            tap0_q[$];
  logic [WW-1:0] win_log[$];
  int            fd_q[$];
  int            stall_cnt = 0;

  // Window whose bottom-right pixel is (r,c): centre (r-1,c-1).
  function automatic logic [EW-1:0] model_window(input int r, input int c);
    logic [EW-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*PW +: PW] = img[r-2+k/3][c-2+k%3];
    w[WW +: 2]   = 2'(r - 1);
    w[WW+2 +: 2] = 2'(c - 1);
    return w;
  endfunction

  always @(negedge clk) begin
    chk("in_ready", in_ready, !out_valid || out_ready);
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("frame_done", frame_done, exp_fd);
    if (out_valid && exp_q.size() != 0) begin
      e = exp_q[0];
      chk("out_window", out_window, e[WW-1:0]);
      chk("out_row", out_row, e[WW +: 2]);
      chk("out_col", out_col, e[WW+2 +: 2]);
    end
    if (hold_prev) begin
      chk("hold_window", out_window, sv_win);
      chk("hold_row", out_row, sv_row);
      chk("hold_col", out_col, sv_col);
    end
    if (frame_done) fd_q.push_back(cyc);
    if (out_valid && !out_ready) stall_cnt++;

    hold_prev = !rst && out_valid && !out_ready;
    sv_win = out_window;
    sv_row = out_row;
    sv_col = out_col;

    if (rst) begin
      exp_q.delete();
      mr = 0;
      mc = 0;
      exp_fd = 1'b0;
    end else begin
      exp_fd = 1'b0;
      if (out_valid && out_ready && exp_q.size() != 0) begin
        cent_q.push_back(out_row * 10 + out_col);
        tap0_q.push_back(int'(out_window[7:0]));
        win_log.push_back(out_window);
        void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        img[mr][mc] = in_data;
        if (mr >= 2 && mc >= 2) exp_q.push_back(model_window(mr, mc));
        if (mr == H-1 && mc == W-1) exp_fd = 1'b1;
        if (mc == W-1) begin
          mc = 0;
          mr = (mr == H-1) ? 0 : mr + 1;
        end else begin
          mc = mc + 1;
        end
      end
    end
  end

  // 5x3 instance log.
  int            cent2_q[$];
  logic [WW-1:0] win2_q[$];
  int            fd2_cnt = 0;

  always @(negedge clk) begin
    if (out_valid2 && out_ready2) begin
      cent2_q.push_back(out_row2 * 10 + out_col2);
      win2_q.push_back(out_window2);
    end
    if (frame_done2) fd2_cnt++;
  end

  // ---------------------------------------------------------------- out_ready
  // 0: always ready, 1: random, 2: stall 5 cycles on first window, 4: never.
  int mode = 0;
  int hold_n = 0;

  always @(posedge clk) begin
    #1;
    case (mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      2: begin
        if (out_valid && hold_n < 5) begin
          out_ready = 1'b0;
          hold_n++;
        end else begin
          out_ready = 1'b1;
        end
      end
      default: out_ready = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------- drivers
  task automatic drive_pixel(input logic [PW-1:0] d, input int bub);
    int   guard;
    logic acc;
    while ($urandom_range(0, 99) < bub) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    guard    = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic send_frame(input int base, input int bub);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        drive_pixel(pix(base, r, c), bub);
  endtask

  task automatic drain();
    int   g;
    logic done;
    in_valid = 1'b0;
    g = 0;
    done = 1'b0;
    while (!done && g < 100) begin
      @(negedge clk);
      g++;
      done = !out_valid && exp_q.size() == 0;
    end
    if (!done) chk("drain_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    cent_q.delete();
    tap0_q.delete();
    win_log.delete();
    fd_q.delete();
    stall_cnt = 0;
  endtask

  task automatic chk_centres(input string tag, input int nframes);
    int exp_c[4] = '{11, 12, 21, 22};
    chk({tag, "_count"}, cent_q.size(), 4 * nframes);
    for (int i = 0; i < cent_q.size() && i < 4 * nframes; i++)
      chk($sformatf("%s_centre%0d", tag, i), cent_q[i], exp_c[i % 4]);
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    logic [WW-1:0] w0;
    int lit[9] = '{0, 4, 8, 16, 20, 24, 32, 36, 40};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_out_window", out_window, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_col", out_col, 0);
    chk("rst_out_valid2", out_valid2, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: basic frame, always ready
    clear_logs();
    send_frame(0, 0);
    drain();
    chk_centres("s1", 1);
    if (win_log.size() > 0) begin
      w0 = win_log[0];
      for (int k = 0; k < 9; k++)
        chk($sformatf("s1_tap%0d_ch0", k), w0[k*PW +: 8], lit[k]);
      chk("s1_tap8_ch2", w0[8*PW+16 +: 8], 42);
    end else begin
      chk("s1_first_window", 0, 1);
    end
    chk("s1_frame_done_count", fd_q.size(), 1);

    // 2: backpressure on the first window
    clear_logs();
    hold_n = 0;
    mode = 2;
    send_frame(0, 0);
    drain();
    chk_centres("s2", 1);
    chk("s2_stall_cycles", stall_cnt, 5);

    // 3: two frames back to back, second offset by 100
    clear_logs();
    mode = 0;
    @(posedge clk); #1;
    send_frame(0, 0);
    send_frame(100, 0);
    drain();
    chk_centres("s3", 2);
    if (tap0_q.size() >= 5) begin
      chk("s3_f1_tap0", tap0_q[0], 0);
      chk("s3_f2_tap0", tap0_q[4], 100);
    end
    chk("s3_frame_done_count", fd_q.size(), 2);
    if (fd_q.size() == 2) chk("s3_frame_done_gap", fd_q[1] - fd_q[0], 16);

    // 4: reset with a window pending after 11 beats
    mode = 4;
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) drive_pixel(pix(0, i / W, i % W), 0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("s4_out_valid_after_rst", out_valid, 0);
    mode = 0;
    @(posedge clk); #1;
    clear_logs();
    send_frame(0, 0);
    drain();
    chk_centres("s4", 1);

    // 5: random bubbles and random out_ready
    clear_logs();
    mode = 1;
    send_frame(0, 50);
    mode = 0;
    drain();
    chk_centres("s5", 1);

    // 6: 5x3 image
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 5; c++) begin
        in_valid2 = 1'b1;
        in_data2  = pix(0, r, c);
        @(negedge clk);
        chk("s6_in_ready2", in_ready2, 1);
        @(posedge clk); #1;
      end
    end
    in_valid2 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("s6_count", cent2_q.size(), 3);
    if (cent2_q.size() == 3) begin
      chk("s6_centre0", cent2_q[0], 11);
      chk("s6_centre1", cent2_q[1], 12);
      chk("s6_centre2", cent2_q[2], 13);
      w0 = win2_q[2];
      chk("s6_tap0_ch0", w0[7:0], 8);
      chk("s6_tap4_ch0", w0[4*PW +: 8], 28);
      chk("s6_tap8_ch0", w0[8*PW +: 8], 48);
    end
    chk("s6_frame_done_count", fd2_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Upstream feeder for the 3x3 convolution engine of the super-resolution pipeline.
- Accepts a raster-order pixel stream (all channels of one pixel per beat) and buffers two previous image rows in line buffers.
- Emits every fully-interior 3x3 multi-channel window ("valid" padding) with its centre coordinates over a valid/ready handshake.
- Output image per frame is (IMG_H-2) x (IMG_W-2) windows.

Parameters:
IMG_W, 64, pixels per row (>=3)
IMG_H, 64, rows per frame (>=3)
PIX_W, 8, bits per channel sample (unsigned)
CH, 3, channels per pixel

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  pixel beat valid
in_ready  out  1  block can accept a beat
in_data  in  CH*PIX_W  pixel; channel n at bits [n*PIX_W +: PIX_W]
out_valid  out  1  window valid
out_ready  in  1  consumer accepts window
out_window  out  9*CH*PIX_W  tap k=3*dy+dx (dy,dx in 0..2, dy=0 top row, dx=0 left col) at bits [k*CH*PIX_W +: CH*PIX_W], channel packing as in_data
out_row  out  clog2(IMG_H)  centre row of window
out_col  out  clog2(IMG_W)  centre column of window
frame_done  out  1  one-cycle pulse after last pixel of a frame accepted

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Accept: a beat is accepted on a cycle with in_valid && in_ready.
  - in_ready = !out_valid || out_ready (combinational; one-deep output register).
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) hold the position of the next pixel.
  - Advance on each accept: col wraps to 0 and row increments.
  - After (IMG_H-1, IMG_W-1): both wrap to 0 and frame_done pulses high the following cycle for exactly one cycle.
- Storage:
  - Line buffers lb_top and lb_mid, IMG_W entries x CH*PIX_W each.
  - Window register: 3 columns x 3 rows.
- On accept of pixel p at (row,col):
  - Window shifts left by one column.
  - New right column = {lb_top[col], lb_mid[col], p} (top, middle, bottom).
  - Same edge: lb_top[col] <= lb_mid[col], lb_mid[col] <= p.
  - Reads return pre-write contents.
- Emission: if the accepted pixel has row>=2 and col>=2, the next cycle presents:
  - out_valid=1;
  - out_window = the shifted window, including p at tap 8;
  - out_row=row-1, out_col=col-1.
  - Latency is exactly 1 cycle from accept to out_valid.
- Output register update:
  - Loads when an emitting accept occurs.
  - Otherwise out_valid clears when out_ready && out_valid.
  - Simultaneous consume and emitting accept: out_valid stays 1 with new data.
  - While out_valid && !out_ready, all outputs hold stable and no beat is accepted.
- Stale window columns at col 0..1 and stale line buffer contents at rows 0..1 are never emitted. Line buffers need no clearing between frames.
- Frames run back-to-back with no gap cycles required.
- Reset values: out_valid=0, frame_done=0, out_window=0, out_row=0, out_col=0, row=col=0. Line buffer and window contents are don't-care.
- Reset mid-frame: any held window is discarded; the next accepted beat is pixel (0,0) of a new frame.
- in_valid may deassert at any cycle (bubbles); state only changes on accept.

Test Plan:
- Bench parameters: IMG_W=4, IMG_H=4, CH=3, PIX_W=8. Pixel (r,c) channel n = 16*r + 4*c + n.
1. Basic frame, out_ready=1, in_valid=1 continuous, 16 beats -> exactly 4 windows, in order centres (1,1),(1,2),(2,1),(2,2).
   - First window channel 0 taps = 0,4,8,16,20,24,32,36,40.
   - First out_valid appears the cycle after pixel (2,2) is accepted.
   - frame_done pulses once, the cycle after beat 16.
2. Backpressure: hold out_ready=0 for 5 cycles when the first window appears -> out_window/out_row/out_col stable, in_ready=0, no beat lost; the remaining 3 windows are correct after release.
3. Back-to-back frames, second frame values +100, no idle cycle -> 8 windows; second-frame first window channel 0 tap 0 = 100; frame_done pulses twice, 16 beats apart.
4. Reset (rst=1 one cycle) after 11 beats, including with a window pending -> out_valid=0 next cycle; a following full frame yields exactly 4 correct windows.
5. Random in_valid bubbles (~50%) plus random out_ready -> window sequence identical to scenario 1; every output value changes only on handshake.
6. Edge gating: no out_valid during beats for rows 0-1 or cols 0-1. Total windows per frame = 4 for 4x4; with IMG_W=5, IMG_H=3 -> 3 windows, centres (1,1),(1,2),(1,3).
